// File: rtl/pulse_delay_meter.sv
// pulse_delay_meter: measures the delay, in clk cycles, from a rising edge on
// start to the following rising edge on stop. Reports the result with a
// one-cycle valid pulse. Flags expiry, re-arming and unexpected stop edges
// with one-cycle pulses.
//
// Handshake: no back-pressure. valid, timeout, overrun and stray are
// registered one-cycle strobes that the consumer must sample on the cycle
// they are high. delay_val holds its value until the next valid.
//
// busy mirrors the FSM state register directly (busy == 1 exactly in WAIT),
// so a checker can read the state through busy.
//
// TIMEOUT must lie in 1 .. 2^CNT_W-1.
module pulse_delay_meter #(
   parameter int CNT_W   = 8,
   parameter int TIMEOUT = 255
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             en,
   input  logic             start,
   input  logic             stop,
   output logic [CNT_W-1:0] delay_val,
   output logic             valid,
   output logic             busy,
   output logic             timeout,
   output logic             overrun,
   output logic             stray
);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_WAIT = 1'b1;

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [0:0]       state;
   logic [0:0]       nxt_state;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] nxt_cnt;
   logic [CNT_W-1:0] nxt_delay;
   logic             nxt_valid;
   logic             nxt_timeout;
   logic             nxt_overrun;
   logic             nxt_stray;
   logic             start_q;
   logic             stop_q;
   logic             start_edge;
   logic             stop_edge;

   assign start_edge = start & ~start_q;
   assign stop_edge  = stop & ~stop_q;
   assign busy       = (state == S_WAIT);

   // Edge-detect registers keep tracking the inputs even while disabled.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         start_q <= 1'b0;
         stop_q  <= 1'b0;
      end else begin
         start_q <= start;
         stop_q  <= stop;
      end
   end

   // Next-state and strobe decode; strobes default low so each event lasts one cycle.
   always_comb begin
      nxt_state   = state;
      nxt_cnt     = cnt;
      nxt_delay   = delay_val;
      nxt_valid   = 1'b0;
      nxt_timeout = 1'b0;
      nxt_overrun = 1'b0;
      nxt_stray   = 1'b0;
      if (!en) begin
         // Disabling silently abandons any open measurement.
         nxt_state = S_IDLE;
         nxt_cnt   = '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start_edge && stop_edge) begin
                  // Zero-delay echo: report at once, never arm.
                  nxt_delay = '0;
                  nxt_valid = 1'b1;
               end else if (start_edge) begin
                  nxt_cnt   = CNT_ONE;
                  nxt_state = S_WAIT;
               end else if (stop_edge) begin
                  nxt_stray = 1'b1;
               end
            end
            S_WAIT: begin
               if (stop_edge) begin
                  // A stop at cnt == TIMEOUT still counts; it beats expiry.
                  nxt_delay = cnt;
                  nxt_valid = 1'b1;
                  if (start_edge) begin
                     // Back-to-back: the same edge closes one and opens the next.
                     nxt_cnt = CNT_ONE;
                  end else begin
                     nxt_cnt   = '0;
                     nxt_state = S_IDLE;
                  end
               end else if (start_edge) begin
                  nxt_overrun = 1'b1;
                  nxt_cnt     = CNT_ONE;
               end else if (cnt == CNT_MAX) begin
                  // Expiry; cnt never increments past TIMEOUT, so it cannot wrap.
                  nxt_timeout = 1'b1;
                  nxt_cnt     = '0;
                  nxt_state   = S_IDLE;
               end else begin
                  nxt_cnt = cnt + CNT_ONE;
               end
            end
            default: begin
               nxt_state = S_IDLE;
               nxt_cnt   = '0;
            end
         endcase
      end
   end

   // State, counter, result and strobe registers.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state     <= S_IDLE;
         cnt       <= '0;
         delay_val <= '0;
         valid     <= 1'b0;
         timeout   <= 1'b0;
         overrun   <= 1'b0;
         stray     <= 1'b0;
      end else begin
         state     <= nxt_state;
         cnt       <= nxt_cnt;
         delay_val <= nxt_delay;
         valid     <= nxt_valid;
         timeout   <= nxt_timeout;
         overrun   <= nxt_overrun;
         stray     <= nxt_stray;
      end
   end

endmodule
